// File: rtl/hoist_cmd_seq_pkg.sv
// Shared definitions for the hoist command sequencer: state codes, direction codes, defaults.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package hoist_cmd_seq_pkg;

  localparam int ST_W = 3;

  // State codes are visible on estado and shared with the motor FSM side, so they are fixed.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_UP     = 3'd1,
    ST_DOWN   = 3'd2,
    ST_DWELL  = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Request direction: 0 travels to the top limit, 1 travels to the bottom limit.
  localparam logic DIR_TOP  = 1'b0;
  localparam logic DIR_BOTT = 1'b1;

  localparam int DEPTH_DEF     = 4;
  localparam int DWELL_CYC_DEF = 3;
  localparam int WDOG_CYC_DEF  = 16;
  localparam int WDOG_W        = 8;

  // States in which the motor is told to hold position.
  function automatic logic is_hold(input state_e s);
    return (s == ST_IDLE) || (s == ST_DWELL) || (s == ST_HALTED) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/hoist_cmd_seq_if.sv
// Request and motor-command bundle between host logic, the sequencer and the motor FSM.
// Latency: n/a (wires only).
// Backpressure: req_ready low while the request queue is full.
interface hoist_cmd_seq_if;
  import hoist_cmd_seq_pkg::*;

  logic            req_valid;
  logic            req_dir;
  logic            req_ready;
  logic            estop;
  logic            top_lim;
  logic            bott_lim;
  logic            go_up;
  logic            go_down;
  logic            halt;
  logic            busy;
  logic            done;
  logic            fault;
  logic [ST_W-1:0] estado;

  // Sequencer side: consumes requests and limit feedback, drives motor commands and status.
  modport master (
    input  req_valid, req_dir, estop, top_lim, bott_lim,
    output req_ready, go_up, go_down, halt, busy, done, fault, estado
  );

  // Environment side: host requests, estop and motor FSM limit feedback.
  modport slave (
    output req_valid, req_dir, estop, top_lim, bott_lim,
    input  req_ready, go_up, go_down, halt, busy, done, fault, estado
  );

endinterface

// File: rtl/hoist_req_fifo.sv
// Small generic FIFO (DEPTH x WIDTH) with binary pointers carrying an extra wrap bit.
// Latency: a push is visible at pop_dat the cycle after it is accepted.
// Backpressure: pushes are ignored while full (even with a same-cycle pop); pops are ignored while empty.
module hoist_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full is judged on the current pointers only, so a pop cannot make room for a same-cycle push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the queue.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because empty masks stale entries.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/hoist_cmd_seq.sv
// Hoist command sequencer: queues up/down requests, drives go_up/go_down/halt, dwells, reports done/fault.
// Latency: push into empty queue -> head next cycle -> UP/DOWN the cycle after; done one cycle after dwell ends.
// Backpressure: req_ready = queue not full. Optional watchdog on move length enabled by HOIST_WDOG_EN.
module hoist_cmd_seq
  import hoist_cmd_seq_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DWELL_CYC = DWELL_CYC_DEF
`ifdef HOIST_WDOG_EN
  , parameter int WDOG_CYC = WDOG_CYC_DEF
`endif
) (
  input  logic CLK,
  input  logic reset,
  hoist_cmd_seq_if.master bus
);

  localparam int DW = $clog2(DWELL_CYC + 1);

  state_e          state;
  state_e          state_nxt;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            head;
  logic [DW-1:0]   dwell_cnt;
  logic            done_q;
  logic            wdog_exp;

  assign push = bus.req_valid && !full;

  hoist_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1)
  ) u_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (push),
    .push_dat (bus.req_dir),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and queue pop: fault is absorbing, then the both-limits fault, then estop, then normal flow.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (state == ST_FAULT) begin
      state_nxt = ST_FAULT;
    end else if (bus.top_lim && bus.bott_lim) begin
      state_nxt = ST_FAULT;
    end else if (bus.estop) begin
      state_nxt = ST_HALTED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            pop = 1'b1;
            // Already sitting at the requested limit: skip the move and just dwell.
            if (head == DIR_TOP)       state_nxt = bus.top_lim  ? ST_DWELL : ST_UP;
            else if (head == DIR_BOTT) state_nxt = bus.bott_lim ? ST_DWELL : ST_DOWN;
          end
        end
        ST_UP: begin
          if (bus.top_lim)   state_nxt = ST_DWELL;
          else if (wdog_exp) state_nxt = ST_FAULT;
        end
        ST_DOWN: begin
          if (bus.bott_lim)  state_nxt = ST_DWELL;
          else if (wdog_exp) state_nxt = ST_FAULT;
        end
        ST_DWELL: begin
          if (dwell_cnt == '0) state_nxt = ST_IDLE;
        end
        ST_HALTED: begin
          // estop is known low here; the aborted request is simply forgotten.
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_FAULT;
      endcase
    end
  end

  // Moore outputs decoded from the state register, plus the registered done pulse.
  always_comb begin
    bus.go_up     = (state == ST_UP);
    bus.go_down   = (state == ST_DOWN);
    bus.halt      = is_hold(state);
    bus.fault     = (state == ST_FAULT);
    bus.busy      = (state != ST_IDLE) || !empty;
    bus.done      = done_q;
    bus.req_ready = !full;
    bus.estado    = state;
  end

  // Dwell timer: loaded on entry to DWELL, counts down to zero.
  always_ff @(posedge CLK) begin
    if (reset)                                              dwell_cnt <= '0;
    else if (state_nxt == ST_DWELL && state != ST_DWELL)    dwell_cnt <= DW'(DWELL_CYC - 1);
    else if (state == ST_DWELL && dwell_cnt != '0)          dwell_cnt <= dwell_cnt - DW'(1);
  end

  // done is high for exactly the first IDLE cycle after a completed dwell.
  always_ff @(posedge CLK) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == ST_DWELL) && (state_nxt == ST_IDLE);
  end

`ifdef HOIST_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;

  // Move watchdog: restarts on entry to UP/DOWN, counts every cycle spent moving.
  always_ff @(posedge CLK) begin
    if (reset)
      wdog_cnt <= '0;
    else if ((state_nxt == ST_UP || state_nxt == ST_DOWN) && state_nxt != state)
      wdog_cnt <= '0;
    else if (state == ST_UP || state == ST_DOWN)
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
  end

  // Expires on the WDOG_CYC-th cycle of a move unless the target limit arrives that same cycle.
  assign wdog_exp = (wdog_cnt == WDOG_W'(WDOG_CYC - 1));
`else
  assign wdog_exp = 1'b0;
`endif

endmodule

// File: tb/tb_hoist_cmd_seq.sv
`timescale 1ns/1ps
module tb_hoist_cmd_seq;

  localparam int DEPTH = 4;
  localparam int DWELL = 3;
  localparam int WDOG  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  hoist_cmd_seq_if bus();

  hoist_cmd_seq #(
    .DEPTH     (DEPTH),
    .DWELL_CYC (DWELL)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Observed output bundle: {go_up, go_down, halt, done, fault, busy, req_ready, estado}.
  function automatic logic [9:0] obs();
    return {bus.go_up, bus.go_down, bus.halt, bus.done, bus.fault, bus.busy, bus.req_ready, bus.estado};
  endfunction

  // Expected bundle from the state number and the queue-dependent flags.
  function automatic logic [9:0] expv(input int st, input bit dn, input bit bsy, input bit rdy);
    logic [2:0] e;
    e = 3'(st);
    return {st == 1, st == 2, (st == 0) || (st == 3) || (st == 4) || (st == 5), dn, st == 5, bsy, rdy, e};
  endfunction

  // One complete move of a request already popped or about to pop; qleft = requests still queued behind it.
  task automatic run_move(input bit dir, input int hold, input int qleft, input string tag, output int lat);
    logic [9:0] got, ex;
    int waited;
    int st;
    waited = 0;
    st = dir ? 2 : 1;
    while (!(bus.go_up || bus.go_down) && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    lat = waited;
    n_checks++;
    if (waited >= 12) begin
      n_errors++;
      $display("FAIL %s_start: no motor command after %0d cycles, need one within 12", tag, waited);
    end
    for (int i = 0; i <= hold; i++) begin
      got = obs(); ex = expv(st, 0, 1, 1); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL %s_move: got=%b exp=%b", tag, got, ex); end
      if (i < hold) @(negedge clk);
    end
    if (dir) bus.bott_lim = 1'b1; else bus.top_lim = 1'b1;
    for (int i = 0; i < DWELL; i++) begin
      @(negedge clk);
      bus.top_lim = 1'b0; bus.bott_lim = 1'b0;
      got = obs(); ex = expv(3, 0, 1, 1); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL %s_dwell%0d: got=%b exp=%b", tag, i, got, ex); end
    end
    @(negedge clk);
    got = obs(); ex = expv(0, 1, qleft > 0, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL %s_done: got=%b exp=%b", tag, got, ex); end
  endtask

  task automatic test_reset(input string tag);
    logic [9:0] got, ex;
    bus.req_valid = 0; bus.req_dir = 0; bus.estop = 0; bus.top_lim = 0; bus.bott_lim = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = obs(); ex = expv(0, 0, 0, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL %s_in_reset: got=%b exp=%b", tag, got, ex); end
    reset = 1'b0;
    @(negedge clk);
    got = obs(); ex = expv(0, 0, 0, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL %s_after_reset: got=%b exp=%b", tag, got, ex); end
  endtask

  task automatic test_single_move();
    logic [9:0] got, ex;
    int lat;
    bus.req_valid = 1; bus.req_dir = 0;
    @(negedge clk);
    bus.req_valid = 0;
    got = obs(); ex = expv(0, 0, 1, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL single_head: got=%b exp=%b", got, ex); end
    run_move(0, 4, 0, "single", lat);
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL single_latency: got=%0d exp=1", lat); end
    @(negedge clk);
    got = obs(); ex = expv(0, 0, 0, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL single_done_once: got=%b exp=%b", got, ex); end
  endtask

  task automatic test_at_limit();
    logic [9:0] got, ex;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) bus.top_lim = 1; else bus.bott_lim = 1;
      bus.req_valid = 1; bus.req_dir = 1'(d);
      @(negedge clk);
      bus.req_valid = 0;
      @(negedge clk);
      bus.top_lim = 0; bus.bott_lim = 0;
      for (int i = 0; i < DWELL; i++) begin
        got = obs(); ex = expv(3, 0, 1, 1); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL at_limit_dwell dir=%0d: got=%b exp=%b", d, got, ex); end
        @(negedge clk);
      end
      got = obs(); ex = expv(0, 1, 0, 1); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL at_limit_done dir=%0d: got=%b exp=%b", d, got, ex); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, ex;
    bit dirs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    bus.estop = 1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.req_valid = 1; bus.req_dir = dirs[k];
      @(negedge clk);
      got = obs(); ex = expv(4, 0, 1, (k + 1) < DEPTH); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL b2b_push%0d: got=%b exp=%b", k, got, ex); end
    end
    bus.req_dir = 1;
    @(negedge clk);
    got = obs(); ex = expv(4, 0, 1, 0); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL b2b_fifth_rejected: got=%b exp=%b", got, ex); end
    bus.req_valid = 0; bus.estop = 0;
    @(negedge clk);
    got = obs(); ex = expv(0, 0, 1, 0); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL b2b_full_idle: got=%b exp=%b", got, ex); end
    bus.req_valid = 1; bus.req_dir = 1;
    @(negedge clk);
    bus.req_valid = 0;
    for (int k = 0; k < DEPTH; k++)
      run_move(dirs[k], int'($urandom_range(0, 3)), DEPTH - 1 - k, "b2b", lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = obs(); ex = expv(0, 0, 0, 1); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL b2b_no_extra: got=%b exp=%b", got, ex); end
    end
  endtask

  task automatic test_estop();
    logic [9:0] got, ex;
    int lat;
    int h;
    bus.req_valid = 1; bus.req_dir = 1;
    @(negedge clk);
    bus.req_dir = 0;
    @(negedge clk);
    bus.req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      got = obs(); ex = expv(2, 0, 1, 1); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL estop_down: got=%b exp=%b", got, ex); end
      @(negedge clk);
    end
    bus.estop = 1;
    h = int'($urandom_range(1, 3));
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      got = obs(); ex = expv(4, 0, 1, 1); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL estop_halted: got=%b exp=%b", got, ex); end
    end
    bus.estop = 0;
    @(negedge clk);
    got = obs(); ex = expv(0, 0, 1, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL estop_release_idle: got=%b exp=%b", got, ex); end
    @(negedge clk);
    run_move(0, int'($urandom_range(0, 4)), 0, "estop_next", lat);
    @(negedge clk);
    got = obs(); ex = expv(0, 0, 0, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL estop_not_resumed: got=%b exp=%b", got, ex); end
    bus.estop = 1;
    @(negedge clk);
    got = obs(); ex = expv(4, 0, 1, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL estop_from_idle: got=%b exp=%b", got, ex); end
    bus.estop = 0;
    @(negedge clk);
    got = obs(); ex = expv(0, 0, 0, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL estop_idle_release: got=%b exp=%b", got, ex); end
  endtask

  task automatic test_fault();
    logic [9:0] got, ex;
    bus.top_lim = 1; bus.bott_lim = 1;
    @(negedge clk);
    bus.top_lim = 0; bus.bott_lim = 0;
    got = obs(); ex = expv(5, 0, 1, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL fault_from_idle: got=%b exp=%b", got, ex); end
    test_reset("fault_idle");
    bus.req_valid = 1; bus.req_dir = 0;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    bus.top_lim = 1; bus.bott_lim = 1;
    @(negedge clk);
    got = obs(); ex = expv(5, 0, 1, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL fault_from_up: got=%b exp=%b", got, ex); end
    bus.top_lim = 0; bus.bott_lim = 0; bus.estop = 1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.req_valid = 1; bus.req_dir = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = obs(); ex = expv(5, 0, 1, (k + 1) < DEPTH); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL fault_queue%0d: got=%b exp=%b", k, got, ex); end
    end
    bus.req_valid = 0; bus.estop = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = obs(); ex = expv(5, 0, 1, 0); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL fault_sticky: got=%b exp=%b", got, ex); end
    end
    test_reset("fault_clear");
  endtask

  task automatic test_random();
    bit q[$];
    int n;
    int lat;
    bit d;
    logic [9:0] got, ex;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, DEPTH));
      q = {};
      bus.estop = 1;
      for (int k = 0; k < n; k++) begin
        d = 1'($urandom_range(0, 1));
        bus.req_valid = 1; bus.req_dir = d;
        q.push_back(d);
        @(negedge clk);
        got = obs(); ex = expv(4, 0, 1, (k + 1) < DEPTH); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL rand_push it=%0d: got=%b exp=%b", it, got, ex); end
      end
      bus.req_valid = 0; bus.estop = 0;
      @(negedge clk);
      got = obs(); ex = expv(0, 0, 1, n < DEPTH); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL rand_release it=%0d: got=%b exp=%b", it, got, ex); end
      while (q.size() > 0) begin
        d = q.pop_front();
        run_move(d, int'($urandom_range(0, 5)), q.size(), "rand", lat);
      end
      @(negedge clk);
      got = obs(); ex = expv(0, 0, 0, 1); n_checks++;
      if (got !== ex) begin n_errors++; $display("FAIL rand_idle it=%0d: got=%b exp=%b", it, got, ex); end
    end
  endtask

  task automatic test_wdog();
    logic [9:0] got, ex;
    int in_down;
    in_down = 0;
    bus.req_valid = 1; bus.req_dir = 1;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    while (bus.estado == 3'd2 && in_down < 100) begin
      in_down++;
      @(negedge clk);
    end
`ifdef HOIST_WDOG_EN
    n_checks++;
    if (in_down !== WDOG) begin n_errors++; $display("FAIL wdog_cycles: got=%0d exp=%0d", in_down, WDOG); end
    got = obs(); ex = expv(5, 0, 1, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL wdog_fault: got=%b exp=%b", got, ex); end
`else
    n_checks++;
    if (in_down !== 100) begin n_errors++; $display("FAIL down_persist: got=%0d exp=100", in_down); end
    got = obs(); ex = expv(2, 0, 1, 1); n_checks++;
    if (got !== ex) begin n_errors++; $display("FAIL down_still: got=%b exp=%b", got, ex); end
`endif
    test_reset("mid_move");
  endtask

  initial begin
    test_reset("start");
    test_single_move();
    test_at_limit();
    test_back_to_back();
    test_estop();
    test_fault();
    test_random();
    test_wdog();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
